// File: rtl/alu_pkg.sv
// Shared ALU definitions: iterative-compare FSM states, SLT op encoding and the
// slice-count helper used to size the iterative set-less-than unit.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SLT  = 1'b0;
    localparam logic OP_SLTU = 1'b1;

    function automatic int nchunk(input int xlen, input int chunk);
        return xlen / chunk;
    endfunction

endpackage

// File: rtl/slt_chunk_cmp.sv
// One CHUNK-bit slice of the iterative compare; flip_msb turns the unsigned
// compare into a two's-complement compare for the top slice.
module slt_chunk_cmp #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq
);

    localparam logic [CHUNK-1:0] MSB_MASK = {1'b1, {(CHUNK-1){1'b0}}};

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    assign a_m = a ^ (flip_msb ? MSB_MASK : '0);
    assign b_m = b ^ (flip_msb ? MSB_MASK : '0);
    assign lt  = a_m < b_m;
    assign eq  = a == b;

endmodule

// File: rtl/slt_iter.sv
// Iterative SLT/SLTU with equality flag, one slice per cycle from the MSB end.
// Define SLT_ITER_EARLY_EXIT_EN to stop at the first differing slice; otherwise constant time.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   CMP   | comparing slice idx, counting down from NCHUNK-1
//   DONE  | out_valid=1, y/eq held until out_ready
module slt_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            op_unsigned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            y,
    output logic            eq
);

    localparam int NCHUNK = nchunk(XLEN, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    if (XLEN % CHUNK != 0) begin : g_bad_chunk
        $error("slt_iter: XLEN must be a multiple of CHUNK");
    end

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            uns_q, uns_d;
    logic            y_q, y_d;
    logic            eq_q, eq_d;

    logic [CHUNK-1:0] a_sl [NCHUNK];
    logic [CHUNK-1:0] b_sl [NCHUNK];
    logic             flip_msb;
    logic             sl_lt;
    logic             sl_eq;

    for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
        assign a_sl[i] = a_q[i*CHUNK +: CHUNK];
        assign b_sl[i] = b_q[i*CHUNK +: CHUNK];
    end

    // Only the sign-carrying top slice is biased in signed mode.
    assign flip_msb = (uns_q == OP_SLT) && (idx_q == IDX_TOP);

    slt_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .a        (a_sl[idx_q]),
        .b        (b_sl[idx_q]),
        .flip_msb (flip_msb),
        .lt       (sl_lt),
        .eq       (sl_eq)
    );

`ifndef SLT_ITER_EARLY_EXIT_EN
    // Set once the first differing slice has been recorded in y_q.
    logic found_q, found_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) found_q <= 1'b0;
        else     found_q <= found_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            y_q     <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            y_q     <= y_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        y_d     = y_q;
        eq_d    = eq_q;
`ifndef SLT_ITER_EARLY_EXIT_EN
        found_d = found_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    uns_d   = op_unsigned;
                    idx_d   = IDX_TOP;
                    y_d     = 1'b0;
                    eq_d    = 1'b0;
`ifndef SLT_ITER_EARLY_EXIT_EN
                    found_d = 1'b0;
`endif
                    state_d = CMP;
                end
            end
            CMP: begin
`ifdef SLT_ITER_EARLY_EXIT_EN
                if (!sl_eq) begin
                    y_d     = sl_lt;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    y_d     = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`else
                if (!found_q && !sl_eq) begin
                    y_d     = sl_lt;
                    found_d = 1'b1;
                end
                if (idx_q == '0) begin
                    eq_d    = !found_q && sl_eq;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign eq        = eq_q;

endmodule

// File: tb/tb_slt_iter.sv
// Self-checking bench for slt_iter: directed vector table, backpressure and
// mid-operation reset sequences, then randomized operands against a reference model.
module tb_slt_iter;

    localparam int XLEN   = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = XLEN / CHUNK;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            op_unsigned;
    logic            out_valid;
    logic            out_ready;
    logic            y;
    logic            eq;

    int total = 0;
    int bad   = 0;

    slt_iter #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op_unsigned (op_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .eq          (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            uns;
        logic            y;
        logic            eq;
        int              lat_ee;
        int              lat_ct;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic model_y(input logic [XLEN-1:0] x, input logic [XLEN-1:0] z,
                                     input logic uns);
        if (uns) return x < z;
        return $signed(x) < $signed(z);
    endfunction

    // Slices examined: with early exit, stop at the highest slice holding a difference.
    function automatic int model_lat(input logic [XLEN-1:0] x, input logic [XLEN-1:0] z);
`ifdef SLT_ITER_EARLY_EXIT_EN
        for (int s = NCHUNK - 1; s >= 0; s--)
            if (x[s*CHUNK +: CHUNK] != z[s*CHUNK +: CHUNK]) return NCHUNK - s;
`endif
        return NCHUNK;
    endfunction

    task automatic run_op(input string nm, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                          input logic uns, input logic exp_y, input logic exp_eq,
                          input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_ready"}, in_ready, 1);
        a = av;
        b = bv;
        op_unsigned = uns;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op_unsigned = ~uns;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_y"}, y, exp_y);
        chk({nm, "_eq"}, eq, exp_eq);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_out_valid_drop"}, out_valid, 0);
        chk({nm, "_idle"}, in_ready, 1);
    endtask

    vec_t vt[4];

    initial begin
        int n;
        int lat;
        logic [XLEN-1:0] ra, rb;
        logic ru;

        vt[0] = '{a: 64'd10, b: 64'd20, uns: 1'b0, y: 1'b1, eq: 1'b0, lat_ee: 4, lat_ct: 4};
        vt[1] = '{a: -64'sd5, b: 64'd0, uns: 1'b0, y: 1'b1, eq: 1'b0, lat_ee: 1, lat_ct: 4};
        vt[2] = '{a: 64'hFFFF_FFFF_FFFF_FFFB, b: 64'd0, uns: 1'b1, y: 1'b0, eq: 1'b0,
                  lat_ee: 1, lat_ct: 4};
        vt[3] = '{a: 64'd100, b: 64'd100, uns: 1'b0, y: 1'b0, eq: 1'b1, lat_ee: 4, lat_ct: 4};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", y, 0);
        chk("reset_eq", eq, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) begin
`ifdef SLT_ITER_EARLY_EXIT_EN
            lat = vt[i].lat_ee;
`else
            lat = vt[i].lat_ct;
`endif
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].uns, vt[i].y, vt[i].eq, lat);
        end

        // Backpressure: result must hold while out_ready is low, new operands ignored.
        @(negedge clk);
        a = '1;
        b = -64'sd2;
        op_unsigned = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 64'd5;
            b = 64'd6;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_out_valid", i), out_valid, 1);
            chk($sformatf("bp_hold%0d_y", i), y, 0);
            chk($sformatf("bp_hold%0d_eq", i), eq, 0);
            chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        run_op("bp_next", 64'd7, 64'd3, 1'b0, 1'b0, 1'b0, model_lat(64'd7, 64'd3));

        // Reset in the second CMP cycle abandons the compare.
        @(negedge clk);
        a = 64'd10;
        b = 64'd20;
        op_unsigned = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_eq", eq, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_mid_no_result", out_valid, 0);
        end
        run_op("rst_next", 64'd1, 64'd2, 1'b0, 1'b1, 1'b0, model_lat(64'd1, 64'd2));

        for (int i = 0; i < 60; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            ru = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ;
                1: rb = ra;
                2: begin
                    rb = ra;
                    rb[$urandom_range(0, NCHUNK - 1) * CHUNK +: CHUNK] = 16'($urandom);
                end
                default: rb = ra ^ (64'd1 << $urandom_range(0, XLEN - 1));
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, ru, model_y(ra, rb, ru), ra == rb,
                   model_lat(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slt_iter.md
# slt_iter

Iterative, parametrised set-less-than unit for the RISC-V ALU. It compares two XLEN-bit operands as signed (SLT/SLTI) or unsigned (SLTU/SLTIU), one CHUNK-bit slice per cycle, starting from the most significant slice. Operands arrive and results leave on valid/ready handshakes. It replaces the single-cycle combinational slt where XLEN is too wide to close timing in one cycle, and it also produces an equality flag for branch resolution.

## Interface
- XLEN, 64, operand width in bits.
- CHUNK, 16, slice width compared per cycle. XLEN % CHUNK must be 0, otherwise elaboration fails. NCHUNK = XLEN/CHUNK.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  unit can accept operands
- a  input  XLEN  left operand
- b  input  XLEN  right operand
- op_unsigned  input  1  0 = signed (SLT), 1 = unsigned (SLTU)
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- y  output  1  1 when a < b under the selected signedness
- eq  output  1  1 when a == b

## Operation
- States:
  - IDLE: in_ready=1.
  - CMP: in_ready=0; slice index idx counts down from NCHUNK-1.
  - DONE: out_valid=1.
- Accept (in_valid & in_ready at an edge):
  - Register a, b and op_unsigned; internal copies are immune to later input changes.
  - Set idx = NCHUNK-1 and go to CMP.
- CMP, each cycle: compare slice idx of both operands.
  - Slice NCHUNK-1 in signed mode: invert the MSB of each operand slice before the unsigned compare.
  - All other slices, and every slice in unsigned mode: plain unsigned compare.
- CMP exit with early exit compiled in:
  - First differing slice: y = slice_lt, eq = 0, go to DONE.
  - Slice 0 equal: y = 0, eq = 1, go to DONE.
  - Otherwise decrement idx.
- CMP exit with early exit compiled out: the first differing slice's result is recorded and held. All NCHUNK slices are always processed, then the unit goes to DONE.
- DONE: y and eq are held stable while out_ready = 0. On out_valid & out_ready, go to IDLE.
- No overlap: a new input is accepted no earlier than the edge after the result handshake.
- Reset values: state IDLE, out_valid 0, y 0, eq 0, idx 0. in_ready = 1 once reset is deasserted.
- Reset during CMP or DONE abandons the operation. No result is produced.

## Timing
- Accepting edge = edge 0. k = number of slices examined (1..NCHUNK with early exit, always NCHUNK without).
- out_valid rises after edge k and stays high until the handshake edge.
- Throughput: at most one result per k+2 cycles (accept, k compares, handshake edge back to IDLE).
- in_ready is a decode of the registered state only; it has no combinational path from in_valid.
- out_valid, y and eq are registered outputs.

## Configuration
- SLT_ITER_EARLY_EXIT_EN defined: CMP terminates on the first differing slice, so latency depends on the data.
- SLT_ITER_EARLY_EXIT_EN undefined: latency is always NCHUNK (constant time, for timing-side-channel-safe builds).
- Results are identical in both builds.

## Structure
- The shared package alu_pkg holds:
  - the state enum (IDLE, CMP, DONE);
  - the op encoding constants OP_SLT = 0 and OP_SLTU = 1;
  - the NCHUNK derivation helper function.
- One sub-module, slt_chunk_cmp: combinational, CHUNK-bit inputs, a flip_msb input, outputs lt and eq. slt_iter instantiates it once and muxes slices into it by idx.

## Test plan
All scenarios use XLEN=64, CHUNK=16; latencies are given as early-exit / constant-time.
- SLT a=10, b=20 -> y=1, eq=0. Difference is in slice 0, so out_valid 4 edges after accept in both builds.
- SLT a=-5, b=0 -> y=1, eq=0. Latency 1 / 4.
- SLTU a=0xFFFF_FFFF_FFFF_FFFB, b=0 -> y=0, eq=0. Latency 1 / 4.
- SLT a=100, b=100 -> y=0, eq=1. Latency 4.
- Backpressure on SLT a=-1, b=-2:
  - Hold out_ready=0 for 3 cycles -> y=0, eq=0 held and out_valid stays 1; in_ready stays 0 and the in_valid pulse is ignored.
  - Raise out_ready -> IDLE on the next edge, and the next operands are accepted.
- Reset mid-operation:
  - Assert rst in the second CMP cycle of SLT 10 vs 20 -> out_valid=0, y=0, eq=0 immediately; in_ready=1 after rst falls.
  - A new SLT a=1, b=2 -> y=1 with normal latency.
